load_queue: RTL and testbench
=============================

# load_queue

Parametrised, multi-entry, in-order load queue that replaces the single-slot load buffer between the address calculation unit (ACU) and the data memory port. It accepts up to one resolved load per cycle from the ACU and holds up to DEPTH loads in age order. It issues the oldest load to memory when no older stores are pending and the hazard unit is not stalling. A full-queue flush discards all held loads on a pipeline squash.

## Interface
- DEPTH, 4, number of entries; power of two, ≥ 2
- XLEN, 32, address width
- ROB_TAG_LEN, 5, ROB tag width
- CNT_W, $clog2(DEPTH+1), width of occupancy count (derived, not overridden)
---
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; clears all state immediately on assertion
- alloc_enable  in  1  ACU requests allocation this cycle
- alloc_valid  in  1  ACU payload is valid; both alloc_enable and alloc_valid must be high
- alloc_address  in  XLEN  load effective address
- alloc_rd_tag  in  ROB_TAG_LEN  ROB tag of the load
- alloc_mem_size  in  3  funct3 size/sign code, carried through unchanged
- pending_stores  in  1  from ROB; older stores are uncommitted, so the head must not issue
- lb_exec_stall  in  1  from hazard unit; an issued head is not consumed this cycle
- flush  in  1  synchronous squash; drops all entries
- full  out  1  count == DEPTH; the ACU must not allocate
- empty  out  1  count == 0
- count  out  CNT_W  current occupancy
- read_mem  out  1  head is valid and is being presented to memory
- load_address  out  XLEN  head address; 0 when empty
- load_rob_tag  out  ROB_TAG_LEN  head ROB tag; 0 when empty
- load_mem_size  out  3  head size code; 0 when empty

## Operation
- Storage is a circular array of DEPTH entries {valid, address, rd_tag, mem_size}, plus head pointer, tail pointer ($clog2(DEPTH) bits each, wrapping modulo DEPTH) and count.
- Allocation is accepted when `alloc_fire = alloc_enable & alloc_valid & ~full`. On acceptance, write entry[tail], set its valid bit, and increment tail.
- An allocation attempted while full is ignored. Full is evaluated on the pre-edge count; there is no same-cycle bypass from dequeue to allocation.
- Issue: `read_mem = ~empty & ~pending_stores`. Issue is strictly in order; younger entries never bypass the head.
- Dequeue: `deq_fire = read_mem & ~lb_exec_stall`. On dequeue, clear entry[head].valid and increment head.
- Count update:
  - +1 on alloc_fire only
  - −1 on deq_fire only
  - unchanged when both occur
  - never wraps: count stays in 0..DEPTH
- Flush has priority over allocation and dequeue in the same cycle. It clears all valid bits and sets head = tail = count = 0. The load presented that cycle is not consumed by the queue; downstream treats it as squashed.
- Asynchronous reset (reset low):
  - all valid bits, head, tail and count = 0
  - full = 0, empty = 1, read_mem = 0
  - load_address, load_rob_tag, load_mem_size = 0
- Payload registers need not be cleared on reset or flush. The head outputs are gated to 0 whenever the queue is empty.

## Timing
- Allocation to visibility: one cycle. An entry allocated at edge N can drive read_mem in the cycle after edge N at the earliest. Allocation into an empty queue never issues in the same cycle.
- read_mem and the head outputs are combinational from registered state and pending_stores. They remain stable while lb_exec_stall holds the head.
- full, empty and count are purely registered.
- Throughput: one allocation and one dequeue per cycle, sustained. At count == DEPTH with a dequeue, full drops after the edge, and allocation is accepted the following cycle.
- Pointer wrap: tail = DEPTH−1 plus an allocation gives tail = 0. Head wraps the same way.
- Reset released mid-stream: the first edge after deassertion may accept an allocation.

## Test plan
- Reset, then allocate addresses 0x100, 0x104, 0x108 with tags 1, 2, 3 and pending_stores = 0, no stall. Required:
  - read_mem is high from the cycle after the first allocation
  - load_address sequence is 0x100, 0x104, 0x108
  - count returns to 0
  - empty = 1 afterwards
- Fill with DEPTH = 4 entries, then drive a fifth allocation. Required: full = 1, count = 4, the fifth load is dropped, and the head stays at the first entry.
- Full queue with pending_stores = 1 for 3 cycles, then 0. Required:
  - read_mem = 0 for those 3 cycles
  - first issue is the oldest tag
  - simultaneous alloc+dequeue from count = 3 leaves count = 3
- Head presented with lb_exec_stall = 1 for 2 cycles. Required: load_rob_tag is held constant, count is unchanged, and the dequeue happens on the first unstalled cycle.
- Flush with count = 3 while alloc_fire and deq_fire are both asserted in the same cycle. Required: next cycle count = 0, empty = 1, read_mem = 0, and the new load is not retained.
- Run 10 allocate/dequeue pairs through DEPTH = 4 to force pointer wrap, and assert reset low asynchronously mid-cycle. Required:
  - tags emerge in order across the wrap
  - on reset assertion, outputs go to reset values without waiting for a clock edge

Source files
------------

// File: rtl/load_queue_if.sv
// Handshake bundle between the ACU/ROB/hazard side and the load queue.
// It carries the allocation request, the issue controls and the head-of-queue memory request.
interface load_queue_if #(
  parameter int DEPTH       = 4,
  parameter int XLEN        = 32,
  parameter int ROB_TAG_LEN = 5
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                   alloc_enable;
  logic                   alloc_valid;
  logic [XLEN-1:0]        alloc_address;
  logic [ROB_TAG_LEN-1:0] alloc_rd_tag;
  logic [2:0]             alloc_mem_size;
  logic                   pending_stores;
  logic                   lb_exec_stall;
  logic                   flush;
  logic                   full;
  logic                   empty;
  logic [CNT_W-1:0]       count;
  logic                   read_mem;
  logic [XLEN-1:0]        load_address;
  logic [ROB_TAG_LEN-1:0] load_rob_tag;
  logic [2:0]             load_mem_size;

  modport master (
    output alloc_enable, alloc_valid, alloc_address, alloc_rd_tag, alloc_mem_size,
    output pending_stores, lb_exec_stall, flush,
    input  full, empty, count, read_mem, load_address, load_rob_tag, load_mem_size
  );

  modport slave (
    input  alloc_enable, alloc_valid, alloc_address, alloc_rd_tag, alloc_mem_size,
    input  pending_stores, lb_exec_stall, flush,
    output full, empty, count, read_mem, load_address, load_rob_tag, load_mem_size
  );
endinterface

// File: rtl/load_queue.sv
// In-order circular load queue between the ACU and the data memory port.
// It issues the oldest load when no older stores are pending, and a flush drops every entry.
module load_queue #(
  parameter int DEPTH       = 4,
  parameter int XLEN        = 32,
  parameter int ROB_TAG_LEN = 5
) (
  input  logic         clock,
  input  logic         reset,
  load_queue_if.slave  lq
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]       head_q, tail_q;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   full_q, empty_q;
  logic [DEPTH-1:0]       valid_q;
  logic [XLEN-1:0]        addr_mem [DEPTH];
  logic [ROB_TAG_LEN-1:0] tag_mem  [DEPTH];
  logic [2:0]             size_mem [DEPTH];

  logic alloc_fire, read_mem, deq_fire;

  // Full comes from the registered count, so a dequeue never frees a slot for a same-cycle allocation.
  assign alloc_fire = lq.alloc_enable & lq.alloc_valid & ~full_q;
  assign read_mem   = ~empty_q & valid_q[head_q] & ~lq.pending_stores;
  assign deq_fire   = read_mem & ~lq.lb_exec_stall;

  // NOTE: combinational blocks use blocking '=' with a default first, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    case ({alloc_fire, deq_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else if (lq.flush) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      // Head and tail can only alias when the queue is empty or full, so both updates never hit one slot.
      if (alloc_fire) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_W'(1);
      end
      if (deq_fire) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // NOTE: payload storage has no reset; valid bits and the empty gate keep stale data invisible.
  always_ff @(posedge clock) begin
    if (alloc_fire) begin
      addr_mem[tail_q] <= lq.alloc_address;
      tag_mem[tail_q]  <= lq.alloc_rd_tag;
      size_mem[tail_q] <= lq.alloc_mem_size;
    end
  end

  assign lq.full          = full_q;
  assign lq.empty         = empty_q;
  assign lq.count         = count_q;
  assign lq.read_mem      = read_mem;
  assign lq.load_address  = empty_q ? '0 : addr_mem[head_q];
  assign lq.load_rob_tag  = empty_q ? '0 : tag_mem[head_q];
  assign lq.load_mem_size = empty_q ? '0 : size_mem[head_q];
endmodule

// File: tb/tb_load_queue.sv
// Scoreboard bench for load_queue: each accepted allocation is queued as an expected issue.
// Every cycle the head outputs are compared with the oldest expected entry.
module tb_load_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int TAGW  = 5;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [TAGW-1:0] tag;
    logic [2:0]      size;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   m_count = 0;

  always #5 clock = ~clock;

  load_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN), .ROB_TAG_LEN(TAGW)) lq_if ();

  load_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .ROB_TAG_LEN(TAGW)) dut (
    .clock (clock),
    .reset (reset),
    .lq    (lq_if)
  );

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_read_mem"}, 64'(lq_if.read_mem), 64'd0);
    check({pfx, "_full"},     64'(lq_if.full),     64'd0);
    check({pfx, "_empty"},    64'(lq_if.empty),    64'd1);
    check({pfx, "_count"},    64'(lq_if.count),    64'd0);
    check({pfx, "_addr"},     64'(lq_if.load_address),  64'd0);
    check({pfx, "_tag"},      64'(lq_if.load_rob_tag),  64'd0);
    check({pfx, "_size"},     64'(lq_if.load_mem_size), 64'd0);
  endtask

  // Drives one cycle of stimulus, checks outputs on the falling edge, then advances the model.
  task automatic step(input logic alloc, input logic [XLEN-1:0] addr, input logic [TAGW-1:0] tag,
                      input logic [2:0] size, input logic ps, input logic stall, input logic fl);
    logic exp_read, a_fire, d_fire;
    exp_t e;
    lq_if.alloc_enable   = alloc;
    lq_if.alloc_valid    = alloc;
    lq_if.alloc_address  = addr;
    lq_if.alloc_rd_tag   = tag;
    lq_if.alloc_mem_size = size;
    lq_if.pending_stores = ps;
    lq_if.lb_exec_stall  = stall;
    lq_if.flush          = fl;
    @(negedge clock);
    exp_read = (m_count != 0) && !ps;
    check("read_mem", 64'(lq_if.read_mem), 64'(exp_read));
    check("count",    64'(lq_if.count),    64'(m_count));
    check("full",     64'(lq_if.full),     64'(m_count == DEPTH));
    check("empty",    64'(lq_if.empty),    64'(m_count == 0));
    if (m_count != 0) begin
      check("head_addr", 64'(lq_if.load_address),  64'(sb[0].addr));
      check("head_tag",  64'(lq_if.load_rob_tag),  64'(sb[0].tag));
      check("head_size", 64'(lq_if.load_mem_size), 64'(sb[0].size));
    end else begin
      check("idle_addr", 64'(lq_if.load_address),  64'd0);
      check("idle_tag",  64'(lq_if.load_rob_tag),  64'd0);
      check("idle_size", 64'(lq_if.load_mem_size), 64'd0);
    end
    a_fire = alloc && (m_count != DEPTH);
    d_fire = exp_read && !stall;
    if (fl) begin
      sb.delete();
      m_count = 0;
    end else begin
      if (d_fire) void'(sb.pop_front());
      if (a_fire) begin
        e.addr = addr; e.tag = tag; e.size = size;
        sb.push_back(e);
      end
      m_count = m_count + int'(a_fire) - int'(d_fire);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic ps, input logic stall);
    step(1'b0, '0, '0, 3'd0, ps, stall, 1'b0);
  endtask

  initial begin
    lq_if.alloc_enable   = 1'b0;
    lq_if.alloc_valid    = 1'b0;
    lq_if.alloc_address  = '0;
    lq_if.alloc_rd_tag   = '0;
    lq_if.alloc_mem_size = '0;
    lq_if.pending_stores = 1'b0;
    lq_if.lb_exec_stall  = 1'b0;
    lq_if.flush          = 1'b0;
    #12;
    check_reset_outputs("rst");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Basic in-order issue: 0x100, 0x104, 0x108 then drain.
    step(1'b1, 32'h100, 5'd1, 3'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h104, 5'd2, 3'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h108, 5'd3, 3'd4, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    check("drained_count", 64'(lq_if.count), 64'd0);
    check("drained_empty", 64'(lq_if.empty), 64'd1);

    // Fill under pending stores, then a fifth allocation that must be dropped.
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 32'h200 + 32'(i * 4), 5'(4 + i), 3'(i), 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h2f0, 5'd8, 3'd5, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    check("full_held", 64'(lq_if.full), 64'd1);
    check("full_head_tag", 64'(lq_if.load_rob_tag), 64'd4);
    // Dequeue at full with an allocation attempt: no same-cycle bypass.
    step(1'b1, 32'h300, 5'd9, 3'd1, 1'b0, 1'b0, 1'b0);
    // Alloc+dequeue from count 3 keeps count at 3.
    step(1'b1, 32'h304, 5'd10, 3'd1, 1'b0, 1'b0, 1'b0);
    check("alloc_deq_count", 64'(lq_if.count), 64'd3);

    // Stall the head for two cycles, then release.
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    check("stall_count", 64'(lq_if.count), 64'd3);
    idle(1'b0, 1'b0);
    check("post_stall_count", 64'(lq_if.count), 64'd2);

    // Bring count to 3, then flush while alloc and dequeue both fire.
    step(1'b1, 32'h400, 5'd11, 3'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h404, 5'd12, 3'd0, 1'b0, 1'b0, 1'b1);
    check("flush_count", 64'(lq_if.count), 64'd0);
    check("flush_empty", 64'(lq_if.empty), 64'd1);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);

    // Ten alloc/dequeue pairs to push both pointers around the ring.
    for (int i = 0; i < 10; i++)
      step(1'b1, 32'h1000 + 32'(i * 8), 5'(13 + i), 3'(i % 8), 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    check("wrap_empty", 64'(lq_if.empty), 64'd1);

    // Asynchronous reset mid-cycle with entries held.
    step(1'b1, 32'h2000, 5'd24, 3'd3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h2004, 5'd25, 3'd3, 1'b1, 1'b0, 1'b0);
    lq_if.alloc_enable   = 1'b0;
    lq_if.alloc_valid    = 1'b0;
    lq_if.pending_stores = 1'b0;
    #1;
    check("pre_rst_read_mem", 64'(lq_if.read_mem), 64'd1);
    #1;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    sb.delete();
    m_count = 0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    step(1'b1, 32'h3000, 5'd30, 3'd6, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
